glyph_rom_arbiter: RTL and testbench
====================================

GLYPH_ROM_ARBITER -- requirements
Module: glyph_rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the char ROM address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning the char ROM glyph-row width.
REQ-004 The block SHALL have parameter ROM_LAT, default 1, meaning the cycles from rom_addr registered to rom_q valid (1..3).
REQ-005 The block SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port resetn, input, 1, the reset, which is synchronous and active-low.
REQ-007 The block SHALL have port line_start, input, 1, a one-cycle pulse at counterX==0 that flushes state for a new video line.
REQ-008 The block SHALL have port req, input, NUM_REQ, the per-requester fetch request; it is held until granted.
REQ-009 The block SHALL have port req_addr, input, NUM_REQ*ADDR_W, the packed per-requester ROM address; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port gnt, output, NUM_REQ, the combinational one-hot grant; a transfer occurs on req[i]&gnt[i].
REQ-011 The block SHALL have port rom_addr, output, ADDR_W, the registered address to the char ROM.
REQ-012 The block SHALL have port rom_q, input, DATA_W, the char ROM data.
REQ-013 The block SHALL have port rsp_valid, output, 1, a one-cycle pulse meaning rsp_data is valid.
REQ-014 The block SHALL have port rsp_id, output, 3, the index of the requester owning rsp_data.
REQ-015 The block SHALL have port rsp_data, output, DATA_W, the registered copy of rom_q.
REQ-016 The block SHALL have port busy, output, 1, high while any fetch is in flight.

Function
REQ-017 gnt SHALL be at most one-hot and SHALL be 0 when req==0, when line_start==1 or when resetn==0.
REQ-018 Grant selection SHALL scan from pointer rr_ptr upward, modulo NUM_REQ, and SHALL grant the first requester with req set.
REQ-019 On a transfer, rr_ptr SHALL become (granted index + 1) mod NUM_REQ at the clock edge; wrap from NUM_REQ-1 is to 0.
REQ-020 On a transfer, rom_addr SHALL load the granted requester's slice at that edge; otherwise rom_addr SHALL hold its value.
REQ-021 Each transfer SHALL enter a valid/id shift pipeline of depth ROM_LAT+1, with one entry per cycle and throughput of 1 fetch/cycle.
REQ-022 rsp_valid, rsp_id and rsp_data SHALL appear exactly ROM_LAT+1 cycles after the transfer cycle, with rsp_data taken from rom_q ROM_LAT cycles after rom_addr updated.
REQ-023 Responses SHALL be returned in grant order with no reordering and no drop, except on flush.
REQ-024 busy SHALL be the OR of all pipeline valid bits.
REQ-025 line_start SHALL clear all pipeline valid bits and set rr_ptr to 0 at that edge; in-flight responses are discarded and rsp_valid is 0 the next cycle.
REQ-026 When req changes while ungranted, the requester change SHALL be accepted without error; arbitration uses current-cycle req and req_addr.

Reset
REQ-027 While resetn is 0 at a rising edge: rr_ptr SHALL be 0, all pipeline valid bits 0, rom_addr 0, rsp_valid 0, rsp_id 0, rsp_data 0 and busy 0.
REQ-028 A reset asserted mid-fetch SHALL discard in-flight responses; the first grant SHALL be possible in the first cycle with resetn high.

Configuration
REQ-029 With macro GLYPH_ARB_ROUNDROBIN_EN defined, arbitration SHALL be round-robin per REQ-018/019.
REQ-030 Without GLYPH_ARB_ROUNDROBIN_EN, arbitration SHALL be fixed priority with the lowest index winning, rr_ptr SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, with ROM_LAT=1: req=4'b0001 and addr0=8'h35 -> gnt=0001 same cycle, rom_addr=8'h35 next cycle, rsp_valid with rsp_id=0 and rsp_data=ROM[8'h35] two cycles after grant.
REQ-032 With RR enabled, req=4'b1111 held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; 8 responses in the same order, back-to-back.
REQ-033 With RR enabled, req=4'b1001 with rr_ptr=1 -> grant 3 then 0 then 3; without the macro -> grant 0 every cycle.
REQ-034 Three fetches in flight plus a line_start pulse -> no rsp_valid afterwards, busy=0 next cycle, and the next grant scans from requester 0.
REQ-035 line_start coincident with req=4'b0010 -> gnt=0 that cycle; grant of 1 the following cycle.
REQ-036 resetn low for one cycle with ROM_LAT=3 and a full pipeline -> all outputs 0 next cycle, and no stale rsp_valid.

Source files
------------

// File: rtl/glyph_rom_arbiter.sv
// rtl/glyph_rom_arbiter.sv - char ROM fetch arbiter; define GLYPH_ARB_ROUNDROBIN_EN for round-robin, else fixed priority
module glyph_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      line_start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  // One pipeline stage per ROM latency cycle plus the response register stage.
  localparam int DEPTH = ROM_LAT + 1;

  logic             xfer;
  logic [2:0]       gnt_idx;
  logic [DEPTH-1:0] vld_q;
  logic [2:0]       id_q [DEPTH];

`ifdef GLYPH_ARB_ROUNDROBIN_EN
  logic [2:0]       rr_ptr;
`endif

  // Pick the first requesting index, scanning upward from the search start.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    idx     = 0;
    if (resetn && !line_start) begin
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef GLYPH_ARB_ROUNDROBIN_EN
        idx = (int'(rr_ptr) + k) % NUM_REQ;
`else
        idx = k;
`endif
        if (!xfer && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = 3'(idx);
          xfer     = 1'b1;
        end
      end
    end
  end

`ifdef GLYPH_ARB_ROUNDROBIN_EN
  // Advance the search start past the winner; a new line restarts at requester 0.
  always_ff @(posedge clock) begin
    if (!resetn || line_start) begin
      rr_ptr <= 3'd0;
    end else if (xfer) begin
      rr_ptr <= (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
  end
`endif

  // Latch the winner's address toward the ROM; hold it when nobody is granted.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rom_addr <= '0;
    end else if (xfer) begin
      rom_addr <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
    end
  end

  // Valid/id shift pipeline tracking fetches in flight; line_start drops them all.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) id_q[i] <= 3'd0;
    end else begin
      if (line_start) vld_q <= '0;
      else            vld_q <= {vld_q[DEPTH-2:0], xfer};
      id_q[0] <= gnt_idx;
      for (int i = 1; i < DEPTH; i++) id_q[i] <= id_q[i-1];
    end
  end

  // Capture ROM data in the cycle it becomes valid for the oldest fetch.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rsp_data <= '0;
    end else if (vld_q[ROM_LAT-1]) begin
      rsp_data <= rom_q;
    end
  end

  assign rsp_valid = vld_q[ROM_LAT];
  assign rsp_id    = id_q[ROM_LAT];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb/tb_glyph_rom_arbiter.sv - directed self-checking bench for glyph_rom_arbiter at ROM_LAT 1 and 3
module tb_glyph_rom_arbiter;

  logic        clock;
  logic        resetn;
  logic        line_start;
  logic [3:0]  req;
  logic [31:0] req_addr;

  logic [3:0]  gnt_a, gnt_b;
  logic [7:0]  rom_addr_a, rom_addr_b;
  logic [7:0]  rom_q_a, rom_q_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic [2:0]  rsp_id_a, rsp_id_b;
  logic [7:0]  rsp_data_a, rsp_data_b;
  logic        busy_a, busy_b;
  logic [7:0]  rom_s1, rom_s2;

  int n_checks = 0;
  int n_fail   = 0;
  int ids [8];
  int e33 [3];
  bit rr_mode;

  glyph_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .ROM_LAT(1)) dut_a (
    .clock(clock), .resetn(resetn), .line_start(line_start), .req(req), .req_addr(req_addr),
    .gnt(gnt_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a), .rsp_valid(rsp_valid_a),
    .rsp_id(rsp_id_a), .rsp_data(rsp_data_a), .busy(busy_a));

  glyph_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(8), .ROM_LAT(3)) dut_b (
    .clock(clock), .resetn(resetn), .line_start(line_start), .req(req), .req_addr(req_addr),
    .gnt(gnt_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b), .rsp_valid(rsp_valid_b),
    .rsp_id(rsp_id_b), .rsp_data(rsp_data_b), .busy(busy_b));

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  assign rom_q_a = rom_f(rom_addr_a);
  always_ff @(posedge clock) begin
    rom_s1 <= rom_f(rom_addr_b);
    rom_s2 <= rom_s1;
  end
  assign rom_q_b = rom_s2;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
`ifdef GLYPH_ARB_ROUNDROBIN_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    e33[0] = 8; e33[1] = 1; e33[2] = 8;
    resetn = 1'b0; line_start = 1'b0; req = 4'b0001;
    req_addr = {8'h13, 8'h12, 8'h11, 8'h35};
    tick; tick;
    check("rst_gnt", 32'(gnt_a), 0);
    check("rst_rom_addr", 32'(rom_addr_a), 0);
    check("rst_rsp_valid", 32'(rsp_valid_a), 0);
    check("rst_rsp_id", 32'(rsp_id_a), 0);
    check("rst_rsp_data", 32'(rsp_data_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_busy_b", 32'(busy_b), 0);
    check("rst_rom_addr_b", 32'(rom_addr_b), 0);

    // single fetch: grant, address, response latency at both ROM latencies
    resetn = 1'b1; #1;
    check("t1_gnt", 32'(gnt_a), 32'h1);
    tick; req = 4'b0000; #1;
    check("t1_rom_addr", 32'(rom_addr_a), 32'h35);
    check("t1_busy", 32'(busy_a), 1);
    check("t1_rsp_early", 32'(rsp_valid_a), 0);
    tick;
    check("t1_rsp_valid", 32'(rsp_valid_a), 1);
    check("t1_rsp_id", 32'(rsp_id_a), 0);
    check("t1_rsp_data", 32'(rsp_data_a), 32'(rom_f(8'h35)));
    tick;
    check("t1_rsp_done", 32'(rsp_valid_a), 0);
    check("t1_idle", 32'(busy_a), 0);
    check("t1_b_early", 32'(rsp_valid_b), 0);
    tick;
    check("t1_b_valid", 32'(rsp_valid_b), 1);
    check("t1_b_id", 32'(rsp_id_b), 0);
    check("t1_b_data", 32'(rsp_data_b), 32'(rom_f(8'h35)));
    tick;

    // all four requesting for eight cycles, back-to-back responses
    line_start = 1'b1; tick; line_start = 1'b0;
    req_addr = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 10; k++) begin
      req = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) begin
        ids[k] = rr_mode ? (k % 4) : 0;
        check("rr8_gnt", 32'(gnt_a), 32'(1 << ids[k]));
      end
      if (k >= 2) begin
        check("rr8_rsp_valid", 32'(rsp_valid_a), 1);
        check("rr8_rsp_id", 32'(rsp_id_a), 32'(ids[k-2]));
        check("rr8_rsp_data", 32'(rsp_data_a), 32'(rom_f(8'h10 + 8'(ids[k-2]))));
      end
      tick;
    end
    tick; tick; tick;

    // req 1001 with search start at 1
    line_start = 1'b1; tick; line_start = 1'b0;
    req = 4'b0001; #1;
    check("p33_gnt0", 32'(gnt_a), 32'h1);
    tick;
    req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("p33_gnt", 32'(gnt_a), rr_mode ? 32'(e33[k]) : 32'h1);
      tick;
    end
    req = 4'b0000;
    tick; tick; tick; tick; tick;

    // flush three in-flight fetches with line_start
    req = 4'hF;
    tick; tick; tick;
    line_start = 1'b1; #1;
    check("ls_gnt", 32'(gnt_a), 0);
    tick; line_start = 1'b0; #1;
    check("ls_rsp_a", 32'(rsp_valid_a), 0);
    check("ls_rsp_b", 32'(rsp_valid_b), 0);
    check("ls_busy_a", 32'(busy_a), 0);
    check("ls_busy_b", 32'(busy_b), 0);
    check("ls_rescan", 32'(gnt_a), 32'h1);
    tick; req = 4'b0000; #1;
    check("ls_stale_a", 32'(rsp_valid_a), 0);
    check("ls_stale_b", 32'(rsp_valid_b), 0);
    tick; tick; tick; tick; tick;

    // line_start coincident with a request
    req = 4'b0010; line_start = 1'b1; #1;
    check("lsreq_gnt", 32'(gnt_a), 0);
    tick; line_start = 1'b0; #1;
    check("lsreq_next", 32'(gnt_a), 32'h2);
    tick; req = 4'b0000;
    tick; tick; tick; tick; tick;

    // reset with a full ROM_LAT=3 pipeline
    req = 4'hF;
    tick; tick; tick; tick;
    check("full_busy_b", 32'(busy_b), 1);
    resetn = 1'b0; #1;
    check("mr_gnt", 32'(gnt_a), 0);
    tick; req = 4'b0000; #1;
    check("mr_rsp_valid_b", 32'(rsp_valid_b), 0);
    check("mr_rsp_id_b", 32'(rsp_id_b), 0);
    check("mr_rsp_data_b", 32'(rsp_data_b), 0);
    check("mr_rom_addr_b", 32'(rom_addr_b), 0);
    check("mr_busy_b", 32'(busy_b), 0);
    check("mr_rsp_data_a", 32'(rsp_data_a), 0);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("mr_stale_b", 32'(rsp_valid_b), 0);
      check("mr_stale_a", 32'(rsp_valid_a), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
